// File: rtl/axi_conv_result_streamer.sv
// Narrows conv-engine sums and streams one frame per frame_start over AXI-Stream. A result accepted on an empty pipeline is valid on the next cycle.
// Backpressure: res_ready drops when FIFO+skid hold FIFO_DEPTH beats. An offer that is not accepted is lost and sets drop_err.
module axi_conv_result_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int SUM_WIDTH  = 64,
  parameter bit SATURATE   = 1'b1,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset_n,
  input  logic                  frame_start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  res_valid,
  input  logic [SUM_WIDTH-1:0]  res_data,
  output logic                  res_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic                  drop_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  acc_cnt_q;
  logic                  drop_q;

  logic [DATA_WIDTH-1:0] nar_dat;

  generate
    if (SUM_WIDTH <= DATA_WIDTH) begin : g_sext
      assign nar_dat = DATA_WIDTH'($signed(res_data));
    end else if (SATURATE) begin : g_sat
      // The value fits iff every bit from the DW-1 position upward equals the sign.
      logic [SUM_WIDTH-DATA_WIDTH:0] upper;
      logic                          fits;
      assign upper   = res_data[SUM_WIDTH-1:DATA_WIDTH-1];
      assign fits    = (&upper) | ~(|upper);
      assign nar_dat = fits ? res_data[DATA_WIDTH-1:0] :
                       res_data[SUM_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                               {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else begin : g_trunc
      assign nar_dat = res_data[DATA_WIDTH-1:0];
    end
  endgenerate

  logic [DATA_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         mem_cnt_q, mem_cnt_d;
  logic                  out_vld_q, out_last_q;
  logic [DATA_WIDTH-1:0] out_dat_q;

  logic [CW-1:0] fifo_count;
  logic          push, push_last, out_ld, mem_empty, pop_mem, bypass, wr_mem, hs_last, start_ok;

  assign fifo_count = mem_cnt_q + CW'(out_vld_q);
  assign res_ready  = (state_q == STREAM) && (fifo_count < CW'(FIFO_DEPTH));
  assign push       = res_valid && res_ready;
  assign push_last  = (acc_cnt_q == len_q - LEN_WIDTH'(1));
  assign out_ld     = !out_vld_q || m_axis_ready;
  assign mem_empty  = (mem_cnt_q == '0);
  assign pop_mem    = out_ld && !mem_empty;
  // With nothing queued ahead, a fresh result goes straight to the skid register.
  assign bypass     = out_ld && mem_empty && push;
  assign wr_mem     = push && !bypass;
  assign hs_last    = out_vld_q && m_axis_ready && out_last_q;
  assign start_ok   = (state_q == IDLE) && frame_start && (frame_len != '0);

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    if (wr_mem && !pop_mem)      mem_cnt_d = mem_cnt_q + CW'(1);
    else if (!wr_mem && pop_mem) mem_cnt_d = mem_cnt_q - CW'(1);
  end

  always_ff @(posedge axi_clk) begin
    if (wr_mem) mem_q[wr_ptr_q] <= {push_last, nar_dat};
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (wr_mem)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_mem) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (out_ld) begin
        if (pop_mem) begin
          out_vld_q                <= 1'b1;
          {out_last_q, out_dat_q}  <= mem_q[rd_ptr_q];
        end else if (bypass) begin
          out_vld_q  <= 1'b1;
          out_last_q <= push_last;
          out_dat_q  <= nar_dat;
        end else begin
          out_vld_q  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      acc_cnt_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      if (res_valid && !res_ready) drop_q <= 1'b1;
      else if (start_ok)           drop_q <= 1'b0;
      case (state_q)
        IDLE: if (start_ok) begin
          state_q   <= STREAM;
          len_q     <= frame_len;
          acc_cnt_q <= '0;
        end
        STREAM: if (push) begin
          acc_cnt_q <= acc_cnt_q + LEN_WIDTH'(1);
          if (push_last) state_q <= DRAIN;
        end
        DRAIN: if (hs_last) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_valid = out_vld_q;
  assign m_axis_data  = out_dat_q;
  assign m_axis_last  = out_last_q;
  assign busy         = (state_q != IDLE);
  assign drop_err     = drop_q;

endmodule
